rf_op_sequencer: RTL and testbench

- Initiator for the 32x16 register file: accepts one ALU command (op, rd, rs1, rs2) per handshake and drives the RF read/write port signals.
- Issues both reads with a one-cycle valid_address strobe, waits RD_LAT cycles, captures read_data1/2, computes, then issues a one-cycle write-back strobe.
- Returns the result on a valid/ready response port; sits between the instruction decode stage and the register file.

---
 rtl/rf_seq_pkg.sv | 28 ++
 rtl/rf_seq_alu.sv | 38 +++
 rtl/rf_op_sequencer.sv | 165 ++++++++++++++++
 tb/tb_rf_op_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_seq_pkg.sv
// Shared types and constants for the register-file operation sequencer.
package rf_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_EXEC     = 3'd3,
        S_WR_ISSUE = 3'd4,
        S_RESP     = 3'd5
    } state_e;

    // Bit positions inside valid_address
    localparam int VA_RD2 = 2;
    localparam int VA_RD1 = 1;
    localparam int VA_WR  = 0;

    // Wide enough for RD_LAT-1 with RD_LAT up to 15
    localparam int CNT_W = 4;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer: ADD/SUB (wrapping, signed overflow), AND, XOR.
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    // Operation select and overflow detection
    always_comb begin
        result = {DATA_W{1'b0}};
        ovf    = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                result = op_a + op_b;
                ovf    = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                         (result[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_SUB: begin
                result = op_a - op_b;
                ovf    = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                         (result[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_AND: result = op_a & op_b;
            OP_XOR: result = op_a ^ op_b;
            default: begin
                result = {DATA_W{1'b0}};
                ovf    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rf_op_sequencer.sv
// Register-file initiator: read two operands, compute, write back, return result.
// Optional macro RF_SEQ_ZERO_REG_EN makes r0 read as zero and ignore writes.
module rf_op_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    output logic [ADDR_W-1:0] read_address1,
    output logic [ADDR_W-1:0] read_address2,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic [2:0]        valid_address,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_ovf
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d, ra1_q, ra1_d, ra2_q, ra2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    logic              ovf_q, ovf_d, rsp_valid_q, rsp_valid_d;
    logic [2:0]        va_q, va_d;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_ovf_s;

    rf_seq_alu #(.DATA_W(DATA_W)) u_alu (
        .op_a   (opa_q),
        .op_b   (opb_q),
        .op     (op_q),
        .result (alu_res_s),
        .ovf    (alu_ovf_s)
    );

    // Strobes are computed one state ahead so valid_address comes straight from a flop
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        ra1_d       = ra1_q;
        ra2_d       = ra2_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        res_d       = res_q;
        ovf_d       = ovf_q;
        rsp_valid_d = rsp_valid_q;
        va_d        = 3'b000;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d           = op_e'(req_op);
                    rd_d           = req_rd;
                    ra1_d          = req_rs1;
                    ra2_d          = req_rs2;
                    va_d[VA_RD2]   = 1'b1;
                    va_d[VA_RD1]   = 1'b1;
                    state_d        = S_RD_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_ISSUE: begin
                cnt_d   = CNT_W'(RD_LAT - 1);
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
`ifdef RF_SEQ_ZERO_REG_EN
                    opa_d = (ra1_q == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : read_data1;
                    opb_d = (ra2_q == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : read_data2;
`else
                    opa_d = read_data1;
                    opb_d = read_data2;
`endif
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_EXEC: begin
                res_d = alu_res_s;
                ovf_d = alu_ovf_s;
`ifdef RF_SEQ_ZERO_REG_EN
                va_d[VA_WR] = (rd_q != {ADDR_W{1'b0}});
`else
                va_d[VA_WR] = 1'b1;
`endif
                state_d = S_WR_ISSUE;
            end
            S_WR_ISSUE: begin
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            rd_q        <= {ADDR_W{1'b0}};
            ra1_q       <= {ADDR_W{1'b0}};
            ra2_q       <= {ADDR_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            opa_q       <= {DATA_W{1'b0}};
            opb_q       <= {DATA_W{1'b0}};
            res_q       <= {DATA_W{1'b0}};
            ovf_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            va_q        <= 3'b000;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            ra1_q       <= ra1_d;
            ra2_q       <= ra2_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
            rsp_valid_q <= rsp_valid_d;
            va_q        <= va_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign read_address1 = ra1_q;
    assign read_address2 = ra2_q;
    assign write_address = rd_q;
    assign write_data    = res_q;
    assign valid_address = va_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = res_q;
    assign rsp_ovf       = ovf_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed bench for rf_op_sequencer: vector table plus stall, reset-abort, RD_LAT=3 and r0 sequences.
module tb_rf_op_sequencer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              req_valid, req_ready, rsp_valid, rsp_ready, rsp_ovf;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_rd, req_rs1, req_rs2;
    logic [ADDR_W-1:0] read_address1, read_address2, write_address;
    logic [DATA_W-1:0] write_data, read_data1, read_data2, rsp_data;
    logic [2:0]        valid_address;

    rf_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .read_address1(read_address1), .read_address2(read_address2),
        .write_address(write_address), .write_data(write_data),
        .valid_address(valid_address),
        .read_data1(read_data1), .read_data2(read_data2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ovf(rsp_ovf)
    );

    // Second instance exercising a three-cycle read latency
    logic              u3_req_valid, u3_req_ready, u3_rsp_valid, u3_rsp_ovf;
    logic [1:0]        u3_req_op;
    logic [ADDR_W-1:0] u3_req_rd, u3_req_rs1, u3_req_rs2, u3_ra1, u3_ra2, u3_wa;
    logic [DATA_W-1:0] u3_wd, u3_rd1, u3_rd2, u3_rsp_data;
    logic [2:0]        u3_va;
    logic              u3_rsp_ready;

    rf_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(u3_req_valid), .req_ready(u3_req_ready), .req_op(u3_req_op),
        .req_rd(u3_req_rd), .req_rs1(u3_req_rs1), .req_rs2(u3_req_rs2),
        .read_address1(u3_ra1), .read_address2(u3_ra2),
        .write_address(u3_wa), .write_data(u3_wd),
        .valid_address(u3_va),
        .read_data1(u3_rd1), .read_data2(u3_rd2),
        .rsp_valid(u3_rsp_valid), .rsp_ready(u3_rsp_ready),
        .rsp_data(u3_rsp_data), .rsp_ovf(u3_rsp_ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Register-file model: data is only presented on the exact sampling cycle
    logic [DATA_W-1:0] rf [32];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [DATA_W-1:0] pl_data = '0;
    int                wr_count = 0;
    logic [ADDR_W-1:0] last_wa = '0;
    logic [DATA_W-1:0] last_wd = '0;
    int                pend = 0;
    logic [DATA_W-1:0] cap1 = '0, cap2 = '0;

    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        if (valid_address[0]) begin
            rf[write_address] <= write_data;
            wr_count <= wr_count + 1;
            last_wa  <= write_address;
            last_wd  <= write_data;
        end
        if (valid_address[1]) begin
            pend <= RD_LAT;
            cap1 <= rf[read_address1];
            cap2 <= rf[read_address2];
        end else if (pend != 0) begin
            pend <= pend - 1;
        end
    end
    assign read_data1 = (pend == 1) ? cap1 : 16'hDEAD;
    assign read_data2 = (pend == 1) ? cap2 : 16'hBEEF;

    function automatic logic [DATA_W-1:0] rf3_val(input logic [ADDR_W-1:0] a);
        case (a)
            5'd1:    return 16'h00FF;
            5'd2:    return 16'h0F0F;
            default: return 16'h0000;
        endcase
    endfunction

    int                pend3 = 0;
    logic [DATA_W-1:0] cap31 = '0, cap32 = '0;
    always @(posedge clk) begin
        if (u3_va[1]) begin
            pend3 <= 3;
            cap31 <= rf3_val(u3_ra1);
            cap32 <= rf3_val(u3_ra2);
        end else if (pend3 != 0) begin
            pend3 <= pend3 - 1;
        end
    end
    assign u3_rd1 = (pend3 == 1) ? cap31 : 16'hDEAD;
    assign u3_rd2 = (pend3 == 1) ? cap32 : 16'hBEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] rd,
                           input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                           output logic [DATA_W-1:0] data, output logic ovf, output int lat);
        check("req_ready_idle", req_ready, 1'b1);
        req_op    = op;
        req_rd    = rd;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("rd_strobe", valid_address, 3'b110);
        check("rd_addr1", read_address1, rs1);
        check("rd_addr2", read_address2, rs2);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        data = rsp_data;
        ovf  = rsp_ovf;
    endtask

    typedef struct {
        logic [1:0]        op;
        logic [ADDR_W-1:0] rd, rs1, rs2;
        logic [DATA_W-1:0] a, b, res;
        logic              ovf;
    } vec_t;

    vec_t              vecs [7];
    logic [DATA_W-1:0] got_d;
    logic              got_o;
    int                lat, w0;

    initial begin
        vecs[0] = '{2'b00, 5'd3, 5'd1, 5'd2, 16'h0005, 16'h0003, 16'h0008, 1'b0};
        vecs[1] = '{2'b00, 5'd4, 5'd1, 5'd2, 16'h7FFF, 16'h0001, 16'h8000, 1'b1};
        vecs[2] = '{2'b01, 5'd5, 5'd1, 5'd2, 16'h0000, 16'h0001, 16'hFFFF, 1'b0};
        vecs[3] = '{2'b10, 5'd6, 5'd1, 5'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0};
        vecs[4] = '{2'b11, 5'd7, 5'd1, 5'd2, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b0};
        vecs[5] = '{2'b01, 5'd8, 5'd1, 5'd2, 16'h8000, 16'h0001, 16'h7FFF, 1'b1};
        vecs[6] = '{2'b00, 5'd9, 5'd9, 5'd9, 16'h4000, 16'h4000, 16'h8000, 1'b1};

        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 2'b00; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        rsp_ready = 1'b1;
        u3_req_valid = 1'b0; u3_req_op = 2'b00; u3_req_rd = '0; u3_req_rs1 = '0; u3_req_rs2 = '0;
        u3_rsp_ready = 1'b1;
        #2;
        check("rst_valid_address", valid_address, 3'b000);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 16'h0000);
        check("rst_rsp_ovf", rsp_ovf, 1'b0);
        check("rst_write_data", write_data, 16'h0000);
        check("rst_addrs", {read_address1, read_address2, write_address}, 15'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_req_ready", req_ready, 1'b1);

        for (int i = 0; i < 7; i++) begin
            preload(vecs[i].rs1, vecs[i].a);
            preload(vecs[i].rs2, vecs[i].b);
            w0 = wr_count;
            run_cmd(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, got_d, got_o, lat);
            check("latency", lat, RD_LAT + 4);
            check("rsp_data", got_d, vecs[i].res);
            check("rsp_ovf", got_o, vecs[i].ovf);
            check("wr_count", wr_count, w0 + 1);
            check("wr_addr", last_wa, vecs[i].rd);
            check("wr_data", last_wd, vecs[i].res);
            tick();
            check("rsp_drop", rsp_valid, 1'b0);
            check("req_ready_back", req_ready, 1'b1);
        end

        // Response back-pressure: output held, new request ignored
        preload(5'd1, 16'h0005);
        preload(5'd2, 16'h0003);
        w0 = wr_count;
        rsp_ready = 1'b0;
        run_cmd(2'b00, 5'd3, 5'd1, 5'd2, got_d, got_o, lat);
        check("stall_latency", lat, RD_LAT + 4);
        req_op = 2'b11; req_rd = 5'd10; req_rs1 = 5'd2; req_rs2 = 5'd2;
        req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("stall_rsp_valid", rsp_valid, 1'b1);
            check("stall_rsp_data", rsp_data, 16'h0008);
            check("stall_req_ready", req_ready, 1'b0);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("release_rsp_valid", rsp_valid, 1'b0);
        check("release_req_ready", req_ready, 1'b1);
        repeat (8) tick();
        check("stall_single_write", wr_count, w0 + 1);
        check("stall_no_second_rsp", rsp_valid, 1'b0);

        // Reset pulse while waiting on read data aborts the command
        w0 = wr_count;
        req_op = 2'b00; req_rd = 5'd11; req_rs1 = 5'd1; req_rs2 = 5'd2;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_valid_address", valid_address, 3'b000);
        #2;
        rst_n = 1'b1;
        tick();
        check("abort_req_ready", req_ready, 1'b1);
        for (int k = 0; k < 8; k++) begin
            check("abort_no_rsp", rsp_valid, 1'b0);
            tick();
        end
        check("abort_no_write", wr_count, w0);

        // Three-cycle read latency instance
        u3_req_op = 2'b11; u3_req_rd = 5'd7; u3_req_rs1 = 5'd1; u3_req_rs2 = 5'd2;
        u3_req_valid = 1'b1;
        tick();
        u3_req_valid = 1'b0;
        check("lat3_rd_strobe", u3_va, 3'b110);
        lat = 1;
        while (!u3_rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("lat3_latency", lat, 7);
        check("lat3_rsp_data", u3_rsp_data, 16'h0FF0);
        check("lat3_rsp_ovf", u3_rsp_ovf, 1'b0);

        // Register 0 behaviour depends on the build
        preload(5'd0, 16'h1234);
        preload(5'd2, 16'h0003);
        w0 = wr_count;
        run_cmd(2'b00, 5'd0, 5'd0, 5'd2, got_d, got_o, lat);
        check("r0_latency", lat, RD_LAT + 4);
`ifdef RF_SEQ_ZERO_REG_EN
        check("r0_rsp_data", got_d, 16'h0003);
        check("r0_no_write", wr_count, w0);
`else
        check("r0_rsp_data", got_d, 16'h1237);
        check("r0_written", wr_count, w0 + 1);
        check("r0_wr_data", last_wd, 16'h1237);
`endif
        tick();
        check("r0_rsp_drop", rsp_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
